adder_seq_arbiter: RTL and testbench

- Shares one SLICE-bit adder slice between two requesters (req0, req1) that each want a WIDTH-bit add.
- Each operation runs low slice to high slice, one slice per cycle, with an internal carry between slices. This trades adder area for latency.
- Sits in front of the adder datapath as its scheduler: round-robin grant, operand capture, slice sequencing, and a result return tagged with the requester id.

---
 rtl/adder_seq_arbiter.sv | 145 ++++++++++++++
 tb/tb_adder_seq_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_arbiter.sv
// Round-robin scheduler for two requesters sharing one SLICE-bit adder; each add ripples low to high, one slice per cycle.
// Optional ADDER_SEQ_CARRY_OUT_EN adds rsp_cout, the carry out of the top slice.
module adder_seq_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             busy
`ifdef ADDER_SEQ_CARRY_OUT_EN
   ,output logic             rsp_cout
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SW     = SLICE + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               id_q, id_d, last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic               cout_q, cout_d;

    logic               grant_c, accept_c, last_slice_c;
    logic [SLICE-1:0]   slice_a_c, slice_b_c;
    logic [SLICE:0]     slice_res_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            cout_q       <= cout_d;
        end
    end

    // Arbitration: a lone requester wins; on contention the one not granted last time wins
    always_comb begin
        grant_c      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        accept_c     = (state_q == IDLE) && (req0_valid || req1_valid);
        last_slice_c = (cnt_q == CNT_W'(NSLICE - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)     state_d = BUSY;
            BUSY:    if (last_slice_c) state_d = DONE;
            DONE:    if (rsp_ready)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath updates
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        cout_d       = cout_q;
        req0_ready   = accept_c && !grant_c;
        req1_ready   = accept_c && grant_c;
        slice_a_c    = '0;
        slice_b_c    = '0;

        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                slice_a_c = a_q[i*SLICE +: SLICE];
                slice_b_c = b_q[i*SLICE +: SLICE];
            end
        end
        slice_res_c = {1'b0, slice_a_c} + {1'b0, slice_b_c} + SW'(carry_q);

        if (state_q == IDLE && accept_c) begin
            a_d          = grant_c ? req1_a : req0_a;
            b_d          = grant_c ? req1_b : req0_b;
            id_d         = grant_c;
            last_grant_d = grant_c;
            carry_d      = 1'b0;
            cnt_d        = '0;
        end

        if (state_q == BUSY) begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
                if (cnt_q == CNT_W'(i)) sum_d[i*SLICE +: SLICE] = slice_res_c[SLICE-1:0];
            end
            carry_d = slice_res_c[SLICE];
            cnt_d   = last_slice_c ? '0 : cnt_q + CNT_W'(1);
            if (last_slice_c) cout_d = slice_res_c[SLICE];
        end

        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign busy      = busy_q;
`ifdef ADDER_SEQ_CARRY_OUT_EN
    assign rsp_cout  = cout_q;
`endif

endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Scoreboard bench for adder_seq_arbiter: directed cases plus randomized traffic against a full-width add model.
module tb_adder_seq_arbiter;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NSLICE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             rsp_valid, rsp_id, busy;
    logic             rsp_ready = 1'b1;
    logic [WIDTH-1:0] rsp_sum;
`ifdef ADDER_SEQ_CARRY_OUT_EN
    logic             rsp_cout;
`endif

    adder_seq_arbiter #(.WIDTH(WIDTH), .SLICE(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy)
`ifdef ADDER_SEQ_CARRY_OUT_EN
       ,.rsp_cout(rsp_cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; } op_t;
    typedef struct { logic id; logic [WIDTH-1:0] sum; logic cout; int unsigned acc; } exp_t;

    op_t         q0[$], q1[$];
    exp_t        sb[$];
    int unsigned glog[$];
    int unsigned cyc = 0;
    int          checks = 0, errors = 0;
    logic        last_m = 1'b1;
    logic        acc0 = 1'b0, acc1 = 1'b0;
    logic        rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input op_t op, input int unsigned c);
        logic [WIDTH:0] full;
        exp_t e;
        full  = {1'b0, op.a} + {1'b0, op.b};
        e.id  = id;
        e.sum = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.acc = c;
        return e;
    endfunction

    // Monitor: arbitration model, busy/valid timing and scoreboard compare
    always @(negedge clk) begin
        logic idle_m, exp_r0, exp_r1, exp_v;
        op_t  op;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (!rst) begin
            idle_m = (sb.size() == 0);
            exp_r0 = idle_m && req0_valid && (!req1_valid || last_m);
            exp_r1 = idle_m && req1_valid && (!req0_valid || !last_m);
            chk("req0_ready", 64'(req0_ready), 64'(exp_r0));
            chk("req1_ready", 64'(req1_ready), 64'(exp_r1));
            chk("busy", 64'(busy), 64'(!idle_m));
            exp_v = !idle_m && (cyc >= sb[0].acc + NSLICE + 1);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            if (rsp_valid && !idle_m) begin
                chk("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                chk("rsp_sum", 64'(rsp_sum), 64'(sb[0].sum));
`ifdef ADDER_SEQ_CARRY_OUT_EN
                chk("rsp_cout", 64'(rsp_cout), 64'(sb[0].cout));
`endif
                if (rsp_ready) void'(sb.pop_front());
            end
            if (exp_r0) begin
                op = '{a: req0_a, b: req0_b};
                sb.push_back(model(1'b0, op, cyc));
                glog.push_back(0);
                last_m = 1'b0;
                acc0 = 1'b1;
            end
            if (exp_r1) begin
                op = '{a: req1_a, b: req1_b};
                sb.push_back(model(1'b1, op, cyc));
                glog.push_back(1);
                last_m = 1'b1;
                acc1 = 1'b1;
            end
        end
    end

    // Requester drivers: hold valid until accepted, then scramble operands and load the next op
    task automatic tick();
        op_t op;
        @(posedge clk);
        #1;
        if (acc0) begin req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; end
        if (acc1) begin req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; end
        if (!req0_valid && q0.size() != 0) begin
            op = q0.pop_front(); req0_a = op.a; req0_b = op.b; req0_valid = 1'b1;
        end
        if (!req1_valid && q1.size() != 0) begin
            op = q1.pop_front(); req1_a = op.a; req1_b = op.b; req1_valid = 1'b1;
        end
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid || sb.size() != 0)
               && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles want < %0d", name, n, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        glog.delete();
        last_m = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_regs(input string tag);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
        chk({tag, "_rsp_sum"}, 64'(rsp_sum), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
`ifdef ADDER_SEQ_CARRY_OUT_EN
        chk({tag, "_rsp_cout"}, 64'(rsp_cout), 64'(0));
`endif
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {$urandom_range(0, 255) > 127 ? 8'h00 : 8'h7F, 24'hFFFFFF};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        // Reset state with no requests pending
        tick();
        tick();
        rst = 1'b0;
        check_reset_regs("reset");
        chk("reset_req0_ready", 64'(req0_ready), 64'(0));
        chk("reset_req1_ready", 64'(req1_ready), 64'(0));

        q0.push_back('{a: 32'h0000_00FF, b: 32'h0000_0001});
        drain("single", 50);
        q1.push_back('{a: 32'hFFFF_FFFF, b: 32'h0000_0001});
        drain("wrap", 50);
        q0.push_back('{a: 32'h00FF_FFFF, b: 32'h0000_0001});
        drain("carry_chain", 50);

        // Contention from reset: grants must alternate starting with req0
        do_reset();
        q0.push_back('{a: 32'h1234_5678, b: 32'h1111_1111});
        q0.push_back('{a: 32'hDEAD_BEEF, b: 32'h0BAD_F00D});
        q1.push_back('{a: 32'h8000_0000, b: 32'h8000_0000});
        q1.push_back('{a: 32'h7FFF_FFFF, b: 32'h0000_0001});
        drain("contention", 100);
        chk("grant_count", 64'(glog.size()), 64'(4));
        for (int i = 0; i < 4 && i < glog.size(); i++)
            chk($sformatf("grant_order_%0d", i), 64'(glog[i]), 64'(i % 2));

        // Backpressure: hold the result in DONE with a competing request waiting
        rsp_ready = 1'b0;
        q0.push_back('{a: 32'hCAFE_0001, b: 32'h0000_FFFF});
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        chk("bp_reached_done", 64'(rsp_valid), 64'(1));
        q1.push_back('{a: 32'h0101_0101, b: 32'h0202_0202});
        repeat (7) tick();
        chk("bp_still_valid", 64'(rsp_valid), 64'(1));
        rsp_ready = 1'b1;
        drain("backpressure", 50);

        // Reset in the second BUSY cycle aborts the op and restores round-robin state
        q1.push_back('{a: 32'h1111_1111, b: 32'h2222_2222});
        n = 0;
        while (!busy && n < 20) begin tick(); n++; end
        chk("midreset_busy_seen", 64'(busy), 64'(1));
        tick();
        rst = 1'b1;
        sb.delete();
        glog.delete();
        last_m = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_regs("midreset");
        q0.push_back('{a: 32'h0000_0010, b: 32'h0000_0020});
        q1.push_back('{a: 32'h0000_0030, b: 32'h0000_0040});
        drain("post_reset", 100);
        chk("post_reset_first_grant", 64'(glog.size() > 0 ? glog[0] : 9), 64'(0));

        // Randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) q0.push_back('{a: pick(), b: pick()});
            if ($urandom_range(0, 9) == 0) q1.push_back('{a: pick(), b: pick()});
            tick();
        end
        drain("random", 4000);
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
